// File: rtl/piso_defs.sv
// Shared definitions for the serial transmit/receive pair: FSM encodings,
// default word width and the counter-width helper.
package piso_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Width of a counter that indexes 0..width-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_register32_bit_counter.sv
// Bit-position counter with synchronous clear, count enable and a
// terminal-count flag raised on the last position of the word.
module bit_counter
  import piso_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over enable so the final beat and a restart both land on zero.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/piso_register32.sv
// Parallel-in/serial-out transmitter: loads a word on a valid/ready handshake
// and drains it one bit per accepted serial beat.
module piso_register32
  import piso_defs::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_done;

  logic             w_tc;
  logic             w_load;
  logic             w_beat;
  logic             w_final;
  logic [WIDTH-1:0] w_shifted;

  assign w_load  = (r_state == ST_IDLE) && in_valid;
  assign w_beat  = (r_state == ST_SHIFT) && ser_ready;
  assign w_final = w_beat && w_tc;

  // Shift toward the output end; the vacated bit fills with zero so a drained
  // register presents 0 on ser_out while idle.
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shreg[WIDTH-1:1]};

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_load || w_final),
    .i_en  (w_beat),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_shreg <= d;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ser_ready) begin
            r_shreg <= w_shifted;
            if (w_tc) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign ser_valid = (r_state == ST_SHIFT);
  assign ser_out   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign ser_last  = ser_valid && w_tc;
  assign done      = r_done;

endmodule

// File: tb/tb_piso_register32.sv
// Bench for piso_register32: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked every cycle against a bit-queue model.
module tb_piso_register32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] d;
  logic         ser_ready;

  logic m_in_ready, m_ser_out, m_ser_valid, m_ser_last, m_done;
  logic l_in_ready, l_ser_out, l_ser_valid, l_ser_last, l_done;
  logic [4:0] obs_m, obs_l;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pending bits in transmit order for each bit order, plus done flag.
  bit qm[$];
  bit ql[$];
  bit exp_done;

  always #5 clk = ~clk;

  piso_register32 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .in_valid(in_valid), .d(d),
    .in_ready(m_in_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .ser_ready(ser_ready), .ser_last(m_ser_last), .done(m_done)
  );

  piso_register32 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_valid(in_valid), .d(d),
    .in_ready(l_in_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .ser_ready(ser_ready), .ser_last(l_ser_last), .done(l_done)
  );

  assign obs_m = {m_in_ready, m_ser_valid, m_ser_out, m_ser_last, m_done};
  assign obs_l = {l_in_ready, l_ser_valid, l_ser_out, l_ser_last, l_done};

  // Expected {in_ready, ser_valid, ser_out, ser_last, done} from the model.
  function automatic logic [4:0] exp_vec(input bit msb);
    logic o;
    o = 1'b0;
    if (msb && qm.size() > 0) o = qm[0];
    if (!msb && ql.size() > 0) o = ql[0];
    return {qm.size() == 0, qm.size() != 0, o, qm.size() == 1, exp_done};
  endfunction

  // Apply inputs for one cycle, advance the model at the edge, settle.
  task automatic cyc(input logic iv, input logic [W-1:0] dv, input logic sr, input logic rs);
    in_valid  = iv;
    d         = dv;
    ser_ready = sr;
    reset     = rs;
    @(posedge clk);
    if (rs) begin
      qm.delete();
      ql.delete();
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (qm.size() == 0) begin
        if (iv) begin
          for (int i = 0; i < W; i++) begin
            qm.push_back(dv[W-1-i]);
            ql.push_back(dv[i]);
          end
        end
      end else if (sr) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
        if (qm.size() == 0) exp_done = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 'x, 1'b1, 1'b1);
    cyc(1'b1, $urandom, 1'b1, 1'b1);
    n_cmp++;
    if (obs_m !== 5'b10000 || obs_l !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset: got m=%b l=%b want 10000", obs_m, obs_l);
    end
  endtask

  task automatic test_idle();
    int pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, (i % 2 == 0) ? 'x : W'($urandom), 1'($urandom), 1'b0);
      if (m_done !== 1'b0 || l_done !== 1'b0 || m_ser_valid !== 1'b0) pulses++;
      n_cmp++;
      if (obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
        n_bad++;
        $display("FAIL idle cyc %0d: got m=%b l=%b want %b", i, obs_m, obs_l, exp_vec(1));
      end
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL idle_quiet: got %0d active cycles want 0", pulses);
    end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] w = 32'h12345678;
    logic [W-1:0] got_m = '0, got_l = '0;
    int lasts = 0;
    cyc(1'b1, w, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) begin
      n_cmp++;
      if (obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
        n_bad++;
        $display("FAIL msb_first beat %0d: got m=%b l=%b want m=%b l=%b",
                 i, obs_m, obs_l, exp_vec(1), exp_vec(0));
      end
      if (m_ser_last === 1'b1) lasts++;
      got_m = {got_m[W-2:0], m_ser_out};
      got_l = {l_ser_out, got_l[W-1:1]};
      cyc(1'b0, $urandom, 1'b1, 1'b0);
    end
    n_cmp++;
    if (m_done !== 1'b1 || m_in_ready !== 1'b1 || m_ser_valid !== 1'b0 || l_done !== 1'b1) begin
      n_bad++;
      $display("FAIL msb_done: got m=%b l=%b want 10001", obs_m, obs_l);
    end
    n_cmp++;
    if (got_m !== w || got_l !== w || lasts != 1) begin
      n_bad++;
      $display("FAIL msb_data: got m=%h l=%h lasts=%0d want %h lasts=1", got_m, got_l, lasts, w);
    end
    cyc(1'b0, 'x, 1'b1, 1'b0);
    n_cmp++;
    if (m_done !== 1'b0 || obs_m !== exp_vec(1)) begin
      n_bad++;
      $display("FAIL msb_done_pulse: got m=%b want %b", obs_m, exp_vec(1));
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] w = 32'h98765432;
    logic [W-1:0] got_l = '0;
    logic [3:0] first4 = '0;
    cyc(1'b1, w, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) begin
      n_cmp++;
      if (obs_l !== exp_vec(0) || obs_m !== exp_vec(1)) begin
        n_bad++;
        $display("FAIL lsb_first beat %0d: got l=%b m=%b want l=%b m=%b",
                 i, obs_l, obs_m, exp_vec(0), exp_vec(1));
      end
      if (i < 4) first4 = {first4[2:0], l_ser_out};
      got_l = {l_ser_out, got_l[W-1:1]};
      cyc(1'b0, 'x, 1'b1, 1'b0);
    end
    n_cmp++;
    if (got_l !== w || first4 !== 4'b0100) begin
      n_bad++;
      $display("FAIL lsb_data: got %h first=%b want %h first=0100", got_l, first4, w);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] w = 32'hffeeddcc;
    logic [W-1:0] got = '0;
    int beats = 0, stalls = 0, vcyc = 0, guard = 0;
    logic held_out, held_last;
    bit sr;
    cyc(1'b1, w, 1'b1, 1'b0);
    while (m_ser_valid === 1'b1 && guard < 200) begin
      guard++;
      vcyc++;
      sr = !(beats == 8 && stalls < 5);
      if (!sr && stalls == 0) begin
        held_out  = m_ser_out;
        held_last = m_ser_last;
      end
      if (!sr && stalls > 0) begin
        n_cmp++;
        if (m_ser_out !== held_out || m_ser_last !== held_last) begin
          n_bad++;
          $display("FAIL stall_hold %0d: got out=%b last=%b want out=%b last=%b",
                   stalls, m_ser_out, m_ser_last, held_out, held_last);
        end
      end
      n_cmp++;
      if (obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
        n_bad++;
        $display("FAIL stall cyc %0d: got m=%b l=%b want m=%b l=%b",
                 vcyc, obs_m, obs_l, exp_vec(1), exp_vec(0));
      end
      if (sr) begin
        got = {got[W-2:0], m_ser_out};
        beats++;
      end else begin
        stalls++;
      end
      cyc(1'b0, 'x, sr, 1'b0);
    end
    n_cmp++;
    if (vcyc != 37 || got !== w || m_done !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_total: got cycles=%0d data=%h done=%b want 37 %h 1", vcyc, got, m_done, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1 = 32'hbbaaccdd, w2 = 32'h77665544;
    logic [W-1:0] got1 = '0, got2 = '0;
    int gap = 0, guard = 0;
    cyc(1'b1, w1, 1'b1, 1'b0);
    while (m_ser_valid === 1'b1 && guard < 100) begin
      guard++;
      n_cmp++;
      if (obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
        n_bad++;
        $display("FAIL b2b first: got m=%b l=%b want m=%b l=%b", obs_m, obs_l, exp_vec(1), exp_vec(0));
      end
      got1 = {got1[W-2:0], m_ser_out};
      cyc(1'b1, w2, 1'b1, 1'b0);
    end
    while (m_ser_valid !== 1'b1 && guard < 100) begin
      guard++;
      gap++;
      n_cmp++;
      if (m_done !== 1'b1 || m_in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b gap: got m=%b want done=1 in_ready=1", obs_m);
      end
      cyc(1'b1, w2, 1'b1, 1'b0);
    end
    while (m_ser_valid === 1'b1 && guard < 100) begin
      guard++;
      n_cmp++;
      if (obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
        n_bad++;
        $display("FAIL b2b second: got m=%b l=%b want m=%b l=%b", obs_m, obs_l, exp_vec(1), exp_vec(0));
      end
      got2 = {got2[W-2:0], m_ser_out};
      cyc(1'b0, 'x, 1'b1, 1'b0);
    end
    n_cmp++;
    if (got1 !== w1 || got2 !== w2 || gap != 1 || guard >= 100) begin
      n_bad++;
      $display("FAIL b2b_data: got %h %h gap=%0d guard=%0d want %h %h gap=1", got1, got2, gap, guard, w1, w2);
    end
    cyc(1'b0, 'x, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w = 32'h12345678;
    logic [W-1:0] got = '0;
    int guard = 0;
    cyc(1'b1, 32'h33221100, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 'x, 1'b1, 1'b0);
    cyc(1'b1, $urandom, 1'b1, 1'b1);
    n_cmp++;
    if (obs_m !== 5'b10000 || obs_l !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_mid: got m=%b l=%b want 10000", obs_m, obs_l);
    end
    cyc(1'b1, w, 1'b1, 1'b0);
    while (m_ser_valid === 1'b1 && guard < 100) begin
      guard++;
      n_cmp++;
      if (obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
        n_bad++;
        $display("FAIL reset_mid word: got m=%b l=%b want m=%b l=%b", obs_m, obs_l, exp_vec(1), exp_vec(0));
      end
      got = {got[W-2:0], m_ser_out};
      cyc(1'b0, 'x, 1'b1, 1'b0);
    end
    n_cmp++;
    if (got !== w || guard != W) begin
      n_bad++;
      $display("FAIL reset_mid_data: got %h beats=%0d want %h beats=32", got, guard, w);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] w = W'($urandom);
      logic [W-1:0] got_m = '0, got_l = '0;
      bit sr;
      int guard = 0;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) cyc(1'b0, $urandom, 1'($urandom), 1'b0);
      cyc(1'b1, w, 1'($urandom), 1'b0);
      while (m_ser_valid === 1'b1 && guard < 400) begin
        guard++;
        sr = ($urandom_range(0, 3) != 0);
        n_cmp++;
        if (obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
          n_bad++;
          $display("FAIL random word %0d: got m=%b l=%b want m=%b l=%b", k, obs_m, obs_l, exp_vec(1), exp_vec(0));
        end
        if (sr) begin
          got_m = {got_m[W-2:0], m_ser_out};
          got_l = {l_ser_out, got_l[W-1:1]};
        end
        cyc(1'($urandom), $urandom, sr, 1'b0);
      end
      n_cmp++;
      if (got_m !== w || got_l !== w || guard >= 400) begin
        n_bad++;
        $display("FAIL random_data %0d: got m=%h l=%h want %h", k, got_m, got_l, w);
      end
      cyc(1'b0, 'x, 1'b1, 1'b0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    d         = '0;
    ser_ready = 1'b0;
    exp_done  = 1'b0;
    test_reset();
    test_idle();
    test_msb_first();
    test_lsb_first();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_register32.md
Name: piso_register32

Overview:
- Parallel-in/serial-out transmitter. Accepts a 32-bit word via a valid/ready load handshake and shifts it out one bit per accepted serial beat.
- It is the read-out counterpart of the 32-bit parallel capture register: it drains a stored word instead of loading one.
- Sits between a word-wide datapath and a 1-bit serial link. A serial-in/parallel-out receiver is the downstream end.

Parameters:
- WIDTH, 32, word width in bits; must be ≥ 2.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  load request; word present on d.
- d  input  WIDTH  parallel word to transmit.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out is a valid beat.
- ser_ready  input  1  downstream accepts the current beat at this edge.
- ser_last  output  1  current beat is the final bit of the word.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- All outputs derive from registers only: state, shreg[WIDTH-1:0], cnt[$clog2(WIDTH)-1:0], done_r. There is no combinational path from inputs to outputs.
- Reset, at the edge with reset=1: state=IDLE, shreg=0, cnt=0, done=0. Resulting outputs: in_ready=1, ser_valid=0, ser_out=0, ser_last=0. Reset has priority over every other event.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, ser_valid=0.
  - Edge with in_valid=1: shreg<=d, cnt<=0, state<=SHIFT.
  - Edge with in_valid=0: hold.
- SHIFT:
  - in_ready=0, ser_valid=1.
  - ser_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - ser_last = (cnt==WIDTH-1).
- Beat accepted (ser_valid & ser_ready at an edge):
  - shreg shifts toward the output end; the vacated bit fills with 0.
  - cnt<=cnt+1.
- Final beat accepted (ser_last & ser_ready): state<=IDLE, cnt<=0, done<=1 for exactly one cycle.
- ser_ready=0 in SHIFT: stall. shreg, cnt, ser_out and ser_last hold. There is no timeout.
- in_valid while in SHIFT is ignored; the word in flight is unaffected and d is not sampled.
- Latency:
  - Load at edge k puts the first bit on ser_out after edge k.
  - With ser_ready held at 1, the last bit is presented in cycle k+WIDTH-1, and done and in_ready are high after edge k+WIDTH.
- Throughput: one word per WIDTH+1 cycles minimum. The IDLE cycle between words is mandatory.
- done and in_ready rise in the same cycle. A load on that cycle is legal and starts the next word.
- Reset mid-SHIFT: the word is discarded and outputs return to reset values after that edge. The next word starts fresh.
- X on d while in_valid=0: no effect.

Decomposition:
- Shared package/include piso_defs:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - CNT_W = $clog2(WIDTH) helper.
  - Default WIDTH constant, shared with the future serial-in/parallel-out receiver.
- One natural sub-module: bit_counter. It is a cnt register with clear, enable and terminal-count output (tc = cnt==WIDTH-1), reused by the receiver.
- Shift register and FSM stay in the top.

Test Plan:
- Reset, then load 32'h12345678 with ser_ready=1, MSB_FIRST=1 -> bits 0,0,0,1,0,0,1,0,… 1,0,0,0. ser_last high only on beat 31, done pulse one cycle later, in_ready=1 again.
- MSB_FIRST=0, load 32'h98765432 -> first bits 0,1,0,0 (LSB of 0x2, then 0x3). The collected 32 bits reassemble to 32'h98765432.
- Load 32'hffeeddcc; drop ser_ready for 5 cycles after beat 7 -> ser_out and ser_last frozen during the stall, total transfer takes 37 cycles, data intact.
- During 32'hbbaaccdd transmission, assert in_valid with d=32'h77665544 -> ignored; stream equals 32'hbbaaccdd. Hold in_valid -> 32'h77665544 loads on the done cycle, leaving exactly one non-valid cycle between the words.
- Load 32'h33221100; assert reset at beat 10 -> after that edge ser_valid=0, in_ready=1, done=0. A following load of 32'h12345678 transmits correctly from bit 0.
- in_valid=0 for 20 cycles after reset -> ser_valid stays 0 and done never pulses.
